// File: rtl/tamagotchi_pkg.sv
// Shared constants for the pet-state core and its input front end:
// default timing at the board clock and the idle level of each input type.
package tamagotchi_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int DEB_CYCLES_DEF  = 1_000_000;    // 20 ms at CLK_HZ
  localparam int HOLD_CYCLES_DEF = 250_000_000;  // 5 s at CLK_HZ

  // Idle level of active-low pushbuttons and of active-high level sensors
  localparam logic IDLE_PB = 1'b1;
  localparam logic IDLE_SW = 1'b0;

endpackage

// File: rtl/antirrebote.sv
// One input channel: 2-flop synchronizer followed by a debouncer that only
// accepts a new level after DEB_CYCLES consecutive clocks of disagreement.
module antirrebote
  import tamagotchi_pkg::*;
#(
  parameter int   DEB_CYCLES = DEB_CYCLES_DEF,
  parameter logic IDLE       = IDLE_PB
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic stable
);

  localparam int             CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  // Synchronizer: starts at the idle level so a held input is seen as a change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= IDLE;
      sync_p1 <= IDLE;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: any return to agreement discards the partial count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= IDLE;
      cnt    <= '0;
    end else if (sync_p1 == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_p1;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/acondicionador_botones.sv
// Input-conditioning front end for Modos: debounces the raw pins, turns care
// buttons into one-clock press pulses, the test button into a single
// long-hold pulse, and passes the sensor levels through debounced.
module acondicionador_botones
  import tamagotchi_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic Bot_Reset,
  input  logic pb_energia_n,
  input  logic pb_medicina_n,
  input  logic pb_test_n,
  input  logic sw_descanso,
  input  logic sw_animo,
  output logic Bot_Energia,
  output logic Bot_Medicina,
  output logic Bot_Test,
  output logic Entrada_Descanso,
  output logic Entrada_Animo
);

  localparam int            HW        = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  // Channel order: 0 energia, 1 medicina, 2 test, 3 descanso, 4 animo
  localparam logic [4:0] IDLE_VEC = {IDLE_SW, IDLE_SW, IDLE_PB, IDLE_PB, IDLE_PB};

  logic [4:0]    stable;
  logic [4:0]    lvl_p2;
  logic [4:0]    lvl_p3;
  logic [HW-1:0] hold;
  logic          test_active;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES), .IDLE(IDLE_PB)) u_deb_energia (
    .clk(clk), .rst_n(Bot_Reset), .din(pb_energia_n),  .stable(stable[0]));
  antirrebote #(.DEB_CYCLES(DEB_CYCLES), .IDLE(IDLE_PB)) u_deb_medicina (
    .clk(clk), .rst_n(Bot_Reset), .din(pb_medicina_n), .stable(stable[1]));
  antirrebote #(.DEB_CYCLES(DEB_CYCLES), .IDLE(IDLE_PB)) u_deb_test (
    .clk(clk), .rst_n(Bot_Reset), .din(pb_test_n),     .stable(stable[2]));
  antirrebote #(.DEB_CYCLES(DEB_CYCLES), .IDLE(IDLE_SW)) u_deb_descanso (
    .clk(clk), .rst_n(Bot_Reset), .din(sw_descanso),   .stable(stable[3]));
  antirrebote #(.DEB_CYCLES(DEB_CYCLES), .IDLE(IDLE_SW)) u_deb_animo (
    .clk(clk), .rst_n(Bot_Reset), .din(sw_animo),      .stable(stable[4]));

  // Stage p2/p3: registered debounced levels; p3 is the previous-level copy for edges
  always_ff @(posedge clk or negedge Bot_Reset) begin
    if (!Bot_Reset) begin
      lvl_p2 <= IDLE_VEC;
      lvl_p3 <= IDLE_VEC;
    end else begin
      lvl_p2 <= stable;
      lvl_p3 <= lvl_p2;
    end
  end

  assign test_active = ~lvl_p3[2];

  // Test hold counter: saturates so a long hold fires only once
  always_ff @(posedge clk or negedge Bot_Reset) begin
    if (!Bot_Reset) begin
      hold <= '0;
    end else if (!test_active) begin
      hold <= '0;
    end else if (hold != HOLD_MAX) begin
      hold <= hold + 1'b1;
    end
  end

  // Output stage: press pulses on falling edge of the active-low level, sensor levels
  always_ff @(posedge clk or negedge Bot_Reset) begin
    if (!Bot_Reset) begin
      Bot_Energia      <= 1'b0;
      Bot_Medicina     <= 1'b0;
      Bot_Test         <= 1'b0;
      Entrada_Descanso <= 1'b0;
      Entrada_Animo    <= 1'b0;
    end else begin
      Bot_Energia      <= lvl_p3[0] & ~lvl_p2[0];
      Bot_Medicina     <= lvl_p3[1] & ~lvl_p2[1];
      Bot_Test         <= test_active && (hold == HOLD_LAST);
      Entrada_Descanso <= lvl_p2[3];
      Entrada_Animo    <= lvl_p2[4];
    end
  end

endmodule

// File: tb/tb_acondicionador_botones.sv
// Directed bench for acondicionador_botones with DEB_CYCLES=4, HOLD_CYCLES=20.
// Edge 0 is the first rising edge that samples a newly driven input level.
module tb_acondicionador_botones;

  localparam int DEB  = 4;
  localparam int HOLD = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Bot_Reset;
  logic pb_energia_n, pb_medicina_n, pb_test_n, sw_descanso, sw_animo;
  logic Bot_Energia, Bot_Medicina, Bot_Test, Entrada_Descanso, Entrada_Animo;

  acondicionador_botones #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk              (clk),
    .Bot_Reset        (Bot_Reset),
    .pb_energia_n     (pb_energia_n),
    .pb_medicina_n    (pb_medicina_n),
    .pb_test_n        (pb_test_n),
    .sw_descanso      (sw_descanso),
    .sw_animo         (sw_animo),
    .Bot_Energia      (Bot_Energia),
    .Bot_Medicina     (Bot_Medicina),
    .Bot_Test         (Bot_Test),
    .Entrada_Descanso (Entrada_Descanso),
    .Entrada_Animo    (Entrada_Animo)
  );

  // Output bit order: 0 energia, 1 medicina, 2 test, 3 descanso, 4 animo
  typedef struct {
    logic       pe, pm, pt, sd, sa;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[24];

  int n_cmp = 0;
  int n_bad = 0;

  int w_edge;
  int w_first[5];
  int w_cnt[5];

  function automatic logic [4:0] outs();
    return {Entrada_Animo, Entrada_Descanso, Bot_Test, Bot_Medicina, Bot_Energia};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic pe, input logic pm, input logic pt,
                       input logic sd, input logic sa);
    pb_energia_n  = pe;
    pb_medicina_n = pm;
    pb_test_n     = pt;
    sw_descanso   = sd;
    sw_animo      = sa;
  endtask

  task automatic w_clear();
    w_edge = 0;
    for (int k = 0; k < 5; k++) begin
      w_first[k] = -1;
      w_cnt[k]   = 0;
    end
  endtask

  // Advance n clocks, recording first edge and number of edges each output is high
  task automatic watch(input int n);
    logic [4:0] o;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      o = outs();
      for (int k = 0; k < 5; k++) begin
        if (o[k] === 1'b1) begin
          if (w_cnt[k] == 0) w_first[k] = w_edge;
          w_cnt[k]++;
        end
      end
      w_edge++;
    end
  endtask

  initial begin
    // Table: energia+medicina pressed rows 0..9, 2-row descanso spike,
    // animo high rows 2..15. Latency through the front end is 7 edges.
    for (int i = 0; i < 24; i++) begin
      tbl[i].pe  = (i < 10) ? 1'b0 : 1'b1;
      tbl[i].pm  = (i < 10) ? 1'b0 : 1'b1;
      tbl[i].pt  = 1'b1;
      tbl[i].sd  = (i == 5 || i == 6);
      tbl[i].sa  = (i >= 2 && i < 16);
      tbl[i].exp = {(i >= 9 && i < 23), 1'b0, 1'b0, (i == 7), (i == 7)};
    end

    // Reset with everything active
    Bot_Reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("reset_outputs", {27'd0, outs()}, 32'd0);
    watch(2);
    check("reset_outputs_held", {27'd0, outs()}, 32'd0);

    // Deassert with buttons still held: one pulse at edge 7, then silence
    Bot_Reset = 1'b1;
    w_clear();
    watch(40);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    watch(20);
    check("post_reset_energia_edge", w_first[0], 7);
    check("post_reset_energia_count", w_cnt[0], 1);
    check("post_reset_medicina_edge", w_first[1], 7);
    check("post_reset_medicina_count", w_cnt[1], 1);
    check("post_reset_test_count", w_cnt[2], 0);
    check("post_reset_descanso_edge", w_first[3], 7);
    check("post_reset_animo_edge", w_first[4], 7);
    check("post_reset_animo_count", w_cnt[4], 40);

    // Table-driven vectors
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].pe, tbl[i].pm, tbl[i].pt, tbl[i].sd, tbl[i].sa);
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 5; k++)
        check($sformatf("vec%0d_out%0d", i, k), outs()[k], tbl[i].exp[k]);
    end
    watch(10);

    // Boundary: 3-clock press rejected, 4-clock press accepted
    w_clear();
    pb_energia_n = 1'b0;
    watch(DEB - 1);
    pb_energia_n = 1'b1;
    watch(15);
    check("short_press_count", w_cnt[0], 0);
    w_clear();
    pb_energia_n = 1'b0;
    watch(DEB);
    pb_energia_n = 1'b1;
    watch(15);
    check("min_press_count", w_cnt[0], 1);
    check("min_press_edge", w_first[0], 7);

    // Bounce: 3-clock levels for 30 clocks, then held low
    w_clear();
    for (int t = 0; t <= 10; t++) begin
      pb_medicina_n = (t % 2 == 0) ? 1'b0 : 1'b1;
      if (t < 10) watch(3);
    end
    watch(20);
    check("bounce_count", w_cnt[1], 1);
    check("bounce_edge", w_first[1], 37);
    check("bounce_energia_quiet", w_cnt[0], 0);
    pb_medicina_n = 1'b1;
    watch(20);
    check("bounce_release_count", w_cnt[1], 1);

    // Test hold: 40 clocks fires once at 7+20; 15 clocks never fires
    w_clear();
    pb_test_n = 1'b0;
    watch(40);
    pb_test_n = 1'b1;
    watch(20);
    check("hold_count", w_cnt[2], 1);
    check("hold_edge", w_first[2], 27);
    w_clear();
    pb_test_n = 1'b0;
    watch(15);
    pb_test_n = 1'b1;
    watch(30);
    check("short_hold_count", w_cnt[2], 0);

    // Reset mid-hold at hold count 15, release during reset
    w_clear();
    pb_test_n = 1'b0;
    watch(23);
    Bot_Reset = 1'b0;
    watch(3);
    check("midhold_reset_outputs", {27'd0, outs()}, 32'd0);
    pb_test_n = 1'b1;
    watch(2);
    Bot_Reset = 1'b1;
    w_clear();
    watch(40);
    check("midhold_after_reset_count", w_cnt[2], 0);
    w_clear();
    pb_test_n = 1'b0;
    watch(40);
    pb_test_n = 1'b1;
    watch(20);
    check("fresh_hold_count", w_cnt[2], 1);
    check("fresh_hold_edge", w_first[2], 27);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
